shift_sequencer: RTL

- Request/response front end for the 32-bit arithmetic-right barrel shifter `sra_module`.
- Latches an operand, a shift amount and an opcode under a valid/ready handshake.
- Drives the shared shifter over one pass (SRA) or two passes (SRL, SLL), then returns a registered result under a second valid/ready handshake.
- Sits between the ALU issue logic and the ALU result mux. It supplies the logical and left shifts without a second shifter instance.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/sra_module.sv | 21 ++
 rtl/shift_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its shifter.
package shift_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SRA = 2'b00,
        OP_SRL = 2'b01,
        OP_SLL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PASS1 = 2'b01,
        ST_PASS2 = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Seed whose arithmetic shift yields a run of leading ones for the mask pass.
    localparam logic [DATA_W-1:0] SIGN_SEED = 32'h8000_0000;

    // Bit reversal: turns a left shift into a right shift and back.
    function automatic logic [DATA_W-1:0] bitrev32(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sra_module.sv
// 32-bit combinational arithmetic-right barrel shifter, five binary-weighted stages.
// Ports: din (operand), select1..select5 (shift by 1/2/4/8/16), dout (result).
module sra_module (
    input  logic [31:0] din,
    input  logic        select1,
    input  logic        select2,
    input  logic        select3,
    input  logic        select4,
    input  logic        select5,
    output logic [31:0] dout
);

    logic [31:0] s1, s2, s3, s4;

    assign s1   = select1 ? 32'($signed(din) >>> 1)  : din;
    assign s2   = select2 ? 32'($signed(s1)  >>> 2)  : s1;
    assign s3   = select3 ? 32'($signed(s2)  >>> 4)  : s2;
    assign s4   = select4 ? 32'($signed(s3)  >>> 8)  : s3;
    assign dout = select5 ? 32'($signed(s4)  >>> 16) : s4;

endmodule

// File: rtl/shift_sequencer.sv
// Request/response front end that derives SRA, SRL and SLL from one
// arithmetic-right shifter using one or two passes.
// Ports: clk, reset (async, active-high); request side req_valid/req_ready,
// req_op, req_data, req_shamt; response side rsp_valid/rsp_ready, rsp_data,
// rsp_err (reserved opcode).
module shift_sequencer
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [SHAMT_W-1:0]  shamt_q;
    logic [DATA_W-1:0]   data_q, acc_q;
    logic [DATA_W-1:0]   sh_in, sh_out, masked;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_err_d;
    logic                accept, acc_load;
    op_e                 req_op_e;

    assign req_op_e = op_e'(req_op);

    // Second pass shifts SIGN_SEED to build the mask of bits vacated by the first pass.
    assign sh_in  = (state_q == ST_PASS2) ? SIGN_SEED : data_q;
    assign masked = acc_q & ~(sh_out << 1);

    sra_module u_sra (
        .din     (sh_in),
        .select1 (shamt_q[0]),
        .select2 (shamt_q[1]),
        .select3 (shamt_q[2]),
        .select4 (shamt_q[3]),
        .select5 (shamt_q[4]),
        .dout    (sh_out)
    );

    // Next-state and response-load decode.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        acc_load   = 1'b0;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_op_e == OP_RSV) begin
                        state_d    = ST_DONE;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = ST_PASS1;
                    end
                end
            end
            ST_PASS1: begin
                acc_load = 1'b1;
                if (op_q == OP_SRA) begin
                    state_d    = ST_DONE;
                    rsp_data_d = sh_out;
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = ST_PASS2;
                end
            end
            ST_PASS2: begin
                state_d    = ST_DONE;
                rsp_data_d = (op_q == OP_SLL) ? bitrev32(masked) : masked;
                rsp_err_d  = 1'b0;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, request latches and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_SRA;
            shamt_q   <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            req_ready <= (state_d == ST_IDLE);
            rsp_valid <= (state_d == ST_DONE);
            if (accept) begin
                op_q    <= req_op_e;
                shamt_q <= req_shamt;
                data_q  <= (req_op_e == OP_SLL) ? bitrev32(req_data) : req_data;
            end
            if (acc_load) begin
                acc_q <= sh_out;
            end
        end
    end

endmodule
